// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush control: load-use and JR stalls, taken-branch flush, IRQ entry FSM with EPC.
// Define HAZARD_PERF_CNT_EN to add the Stall_Cnt/Flush_Cnt/Irq_Cnt performance counters.
module hazard_ctrl #(
   parameter int CNT_WIDTH  = 32,
   parameter int KERNEL_BIT = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ID_Valid,
   input  logic [31:0] ID_PC_plus4,
   input  logic [4:0]  ID_RegisterRs,
   input  logic [4:0]  ID_RegisterRt,
   input  logic        ID_UsesRt,
   input  logic        ID_isJump,
   input  logic        ID_isJR,
   input  logic        ID_isEret,
   input  logic        EX_MemRd,
   input  logic        EX_RegWr,
   input  logic [4:0]  EX_RegisterWr,
   input  logic        EX_isBranch,
   input  logic        EX_BranchTaken,
   input  logic        MEM_MemRd,
   input  logic [4:0]  MEM_RegisterWr,
   input  logic        IRQ,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic [1:0]  PC_Sel,
   output logic [31:0] EPC,
   output logic        Irq_Active
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] Stall_Cnt,
   output logic [CNT_WIDTH-1:0] Flush_Cnt,
   output logic [CNT_WIDTH-1:0] Irq_Cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      IRQ_PEND = 2'd1,
      IRQ_TAKE = 2'd2
   } state_t;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_VECTOR = 2'd3;

   state_t state, state_nxt;

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs;
   logic load_use, jr_hazard, branch_taken, stall;
   logic irq_ok, irq_slot, take_irq, eret_commit;

   // Register $0 never creates a dependency.
   assign ex_hit_rs  = (EX_RegisterWr  != 5'd0) && (EX_RegisterWr  == ID_RegisterRs);
   assign ex_hit_rt  = (EX_RegisterWr  != 5'd0) && (EX_RegisterWr  == ID_RegisterRt);
   assign mem_hit_rs = (MEM_RegisterWr != 5'd0) && (MEM_RegisterWr == ID_RegisterRs);

   assign load_use     = EX_MemRd && (ex_hit_rs || (ID_UsesRt && ex_hit_rt));
   assign jr_hazard    = ID_isJR && ((EX_RegWr && ex_hit_rs) || (MEM_MemRd && mem_hit_rs));
   assign branch_taken = EX_isBranch && EX_BranchTaken;
   assign stall        = load_use || jr_hazard;

   assign irq_ok   = IRQ && !Irq_Active && !ID_PC_plus4[KERNEL_BIT];
   // Only enter the handler on a clean, committed ID instruction so EPC is a safe restart point.
   assign irq_slot = ID_Valid && !stall && !ID_isJump && !ID_isJR && !EX_isBranch;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt   = state;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      PC_Sel      = PC_SEQ;
      take_irq    = 1'b0;
      eret_commit = 1'b0;

      if (!reset) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (branch_taken) begin
         PC_Sel      = PC_BRANCH;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (state == IRQ_TAKE) begin
         PC_Sel      = PC_VECTOR;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         take_irq    = 1'b1;
      end else if (stall) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else if (ID_isJump || ID_isJR) begin
         PC_Sel      = PC_JUMP;
         IF_ID_Flush = 1'b1;
      end else begin
         eret_commit = ID_isEret && ID_Valid;
      end

      case (state)
         RUN: begin
            if (irq_ok) state_nxt = IRQ_PEND;
         end
         IRQ_PEND: begin
            if (!IRQ)          state_nxt = RUN;
            else if (irq_slot) state_nxt = IRQ_TAKE;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         EPC        <= '0;
         Irq_Active <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
         state <= state_nxt;
         if (take_irq) begin
            EPC        <= ID_PC_plus4 - 32'd4;
            Irq_Active <= 1'b1;
         end else if (eret_commit) begin
            Irq_Active <= 1'b0;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Stall_Cnt <= '0;
         Flush_Cnt <= '0;
         Irq_Cnt   <= '0;
      end else begin
         if (!PC_Write)         Stall_Cnt <= Stall_Cnt + CNT_ONE;
         if (branch_taken)      Flush_Cnt <= Flush_Cnt + CNT_ONE;
         if (state == IRQ_TAKE) Irq_Cnt   <= Irq_Cnt + CNT_ONE;
      end
   end
`else
   logic unused_cnt_width;
   assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;

   localparam int CW = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        ID_Valid;
   logic [31:0] ID_PC_plus4;
   logic [4:0]  ID_RegisterRs, ID_RegisterRt;
   logic        ID_UsesRt, ID_isJump, ID_isJR, ID_isEret;
   logic        EX_MemRd, EX_RegWr;
   logic [4:0]  EX_RegisterWr;
   logic        EX_isBranch, EX_BranchTaken;
   logic        MEM_MemRd;
   logic [4:0]  MEM_RegisterWr;
   logic        IRQ;
   logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
   logic [1:0]  PC_Sel;
   logic [31:0] EPC;
   logic        Irq_Active;
`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] Stall_Cnt, Flush_Cnt, Irq_Cnt;
`endif

   hazard_ctrl #(.CNT_WIDTH(CW), .KERNEL_BIT(31)) dut (
      .clk            (clk),
      .reset          (reset),
      .ID_Valid       (ID_Valid),
      .ID_PC_plus4    (ID_PC_plus4),
      .ID_RegisterRs  (ID_RegisterRs),
      .ID_RegisterRt  (ID_RegisterRt),
      .ID_UsesRt      (ID_UsesRt),
      .ID_isJump      (ID_isJump),
      .ID_isJR        (ID_isJR),
      .ID_isEret      (ID_isEret),
      .EX_MemRd       (EX_MemRd),
      .EX_RegWr       (EX_RegWr),
      .EX_RegisterWr  (EX_RegisterWr),
      .EX_isBranch    (EX_isBranch),
      .EX_BranchTaken (EX_BranchTaken),
      .MEM_MemRd      (MEM_MemRd),
      .MEM_RegisterWr (MEM_RegisterWr),
      .IRQ            (IRQ),
      .PC_Write       (PC_Write),
      .IF_ID_Write    (IF_ID_Write),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Flush    (ID_EX_Flush),
      .PC_Sel         (PC_Sel),
      .EPC            (EPC),
      .Irq_Active     (Irq_Active)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .Stall_Cnt      (Stall_Cnt),
      .Flush_Cnt      (Flush_Cnt),
      .Irq_Cnt        (Irq_Cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       pc_write;
      logic       if_id_write;
      logic       if_id_flush;
      logic       id_ex_flush;
      logic [1:0] pc_sel;
   } ctl_t;

   int          m_phase;   // 0 = no interrupt pending, 1 = waiting for a slot, 2 = vectoring
   logic [31:0] m_epc;
   logic        m_active;
   logic [CW-1:0] m_stall, m_flush, m_irqc;

   function automatic bit dep(input logic [4:0] prod, input logic [4:0] cons);
      return (prod != 5'd0) && (prod == cons);
   endfunction

   function automatic bit m_lu();
      return EX_MemRd && (dep(EX_RegisterWr, ID_RegisterRs) ||
                          (ID_UsesRt && dep(EX_RegisterWr, ID_RegisterRt)));
   endfunction

   function automatic bit m_jrh();
      return ID_isJR && ((EX_RegWr && dep(EX_RegisterWr, ID_RegisterRs)) ||
                         (MEM_MemRd && dep(MEM_RegisterWr, ID_RegisterRs)));
   endfunction

   function automatic bit m_br();
      return EX_isBranch && EX_BranchTaken;
   endfunction

   function automatic bit m_stalled();
      return !m_br() && (m_phase != 2) && (m_lu() || m_jrh());
   endfunction

   function automatic ctl_t m_ctl();
      if (!reset)               return ctl_t'{1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      if (m_br())               return ctl_t'{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
      if (m_phase == 2)         return ctl_t'{1'b1, 1'b1, 1'b1, 1'b1, 2'd3};
      if (m_lu() || m_jrh())    return ctl_t'{1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
      if (ID_isJump || ID_isJR) return ctl_t'{1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
      return ctl_t'{1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase  <= 0;
         m_epc    <= '0;
         m_active <= 1'b0;
         m_stall  <= '0;
         m_flush  <= '0;
         m_irqc   <= '0;
      end else begin
         if (m_phase == 2 && !m_br()) begin
            m_epc    <= ID_PC_plus4 - 32'd4;
            m_active <= 1'b1;
         end else if (ID_isEret && ID_Valid && !m_br() && m_phase != 2 && !m_lu() && !m_jrh() &&
                      !ID_isJump && !ID_isJR) begin
            m_active <= 1'b0;
         end
         if (m_phase == 0) begin
            if (IRQ && !m_active && !ID_PC_plus4[31]) m_phase <= 1;
         end else if (m_phase == 1) begin
            if (!IRQ) m_phase <= 0;
            else if (ID_Valid && !EX_isBranch && !m_lu() && !m_jrh() && !ID_isJump && !ID_isJR)
               m_phase <= 2;
         end else begin
            m_phase <= 0;
         end
         if (m_stalled())  m_stall <= m_stall + 1;
         if (m_br())       m_flush <= m_flush + 1;
         if (m_phase == 2) m_irqc  <= m_irqc + 1;
      end
   end

   // Continuous comparison, mid-cycle
   always @(negedge clk) begin
      check("ctl", {58'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Sel}, {58'd0, m_ctl()});
      check("epc_active", {31'd0, Irq_Active, EPC}, {31'd0, m_active, m_epc});
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt", {32'd0, Stall_Cnt}, {32'd0, m_stall});
      check("flush_cnt", {32'd0, Flush_Cnt}, {32'd0, m_flush});
      check("irq_cnt",   {32'd0, Irq_Cnt},   {32'd0, m_irqc});
`endif
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      ID_Valid       = 1'b1;
      ID_PC_plus4    = 32'h0040_0000;
      ID_RegisterRs  = 5'd0;
      ID_RegisterRt  = 5'd0;
      ID_UsesRt      = 1'b0;
      ID_isJump      = 1'b0;
      ID_isJR        = 1'b0;
      ID_isEret      = 1'b0;
      EX_MemRd       = 1'b0;
      EX_RegWr       = 1'b0;
      EX_RegisterWr  = 5'd0;
      EX_isBranch    = 1'b0;
      EX_BranchTaken = 1'b0;
      MEM_MemRd      = 1'b0;
      MEM_RegisterWr = 5'd0;
      IRQ            = 1'b0;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      mid();
      check("rst_pc_write",    PC_Write,    1'b0);
      check("rst_if_id_write", IF_ID_Write, 1'b0);
      check("rst_if_id_flush", IF_ID_Flush, 1'b1);
      check("rst_id_ex_flush", ID_EX_Flush, 1'b1);
      check("rst_pc_sel",      PC_Sel,      2'd0);
      check("rst_epc",         EPC,         32'h0);
      check("rst_irq_active",  Irq_Active,  1'b0);
`ifdef HAZARD_PERF_CNT_EN
      check("rst_stall_cnt", Stall_Cnt, 32'd0);
      check("rst_flush_cnt", Flush_Cnt, 32'd0);
      check("rst_irq_cnt",   Irq_Cnt,   32'd0);
`endif
      next();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      do_reset();

      // Load-use on rs: one bubble, then normal
      ID_RegisterRs = 5'd8; EX_MemRd = 1'b1; EX_RegWr = 1'b1; EX_RegisterWr = 5'd8;
      mid();
      check("lu_pc_write", PC_Write, 1'b0);
      check("lu_if_id_write", IF_ID_Write, 1'b0);
      check("lu_id_ex_flush", ID_EX_Flush, 1'b1);
      next();
      idle(); ID_RegisterRs = 5'd8;
      mid();
      check("lu_after_pc_write", PC_Write, 1'b1);
      check("lu_after_id_ex_flush", ID_EX_Flush, 1'b0);
      next();
      // Load to $0 never stalls
      idle(); EX_MemRd = 1'b1; EX_RegWr = 1'b1; ID_UsesRt = 1'b1;
      mid();
      check("lu_r0_pc_write", PC_Write, 1'b1);
      next();
      // rt dependency only counts when rt is read
      idle(); EX_MemRd = 1'b1; EX_RegisterWr = 5'd9; ID_RegisterRs = 5'd3; ID_RegisterRt = 5'd9;
      mid();
      check("lu_rt_unused", PC_Write, 1'b1);
      next();
      ID_UsesRt = 1'b1;
      mid();
      check("lu_rt_used", PC_Write, 1'b0);
      next();

      // JR after load: two stall cycles then jump
      do_reset();
      idle(); ID_isJR = 1'b1; ID_RegisterRs = 5'd31;
      EX_MemRd = 1'b1; EX_RegWr = 1'b1; EX_RegisterWr = 5'd31;
      mid();
      check("jr_ld_stall1", PC_Write, 1'b0);
      next();
      idle(); ID_isJR = 1'b1; ID_RegisterRs = 5'd31; MEM_MemRd = 1'b1; MEM_RegisterWr = 5'd31;
      mid();
      check("jr_ld_stall2", {PC_Write, ID_EX_Flush}, 2'b01);
      next();
      idle(); ID_isJR = 1'b1; ID_RegisterRs = 5'd31;
      mid();
      check("jr_ld_go", {PC_Sel, IF_ID_Flush, PC_Write}, 4'b1011);
`ifdef HAZARD_PERF_CNT_EN
      check("jr_ld_stall_cnt", Stall_Cnt, 32'd2);
`endif
      next();
      // JR after ALU producer: one stall
      idle(); ID_isJR = 1'b1; ID_RegisterRs = 5'd5; EX_RegWr = 1'b1; EX_RegisterWr = 5'd5;
      mid();
      check("jr_alu_stall", PC_Write, 1'b0);
      next();
      idle(); ID_isJR = 1'b1; ID_RegisterRs = 5'd5;
      mid();
      check("jr_alu_go", PC_Sel, 2'd2);
      next();
      // JR $0 against a $0 writer: no hazard
      idle(); ID_isJR = 1'b1; EX_RegWr = 1'b1;
      mid();
      check("jr_r0", {PC_Sel, PC_Write}, 3'b101);
      next();

      // Taken branch wins over load-use
      idle(); EX_isBranch = 1'b1; EX_BranchTaken = 1'b1;
      EX_MemRd = 1'b1; EX_RegisterWr = 5'd8; ID_RegisterRs = 5'd8;
      mid();
      check("br_lu", {PC_Sel, IF_ID_Flush, ID_EX_Flush, PC_Write}, 5'b01111);
      next();
      idle(); EX_isBranch = 1'b1;
      mid();
      check("br_not_taken", {PC_Sel, IF_ID_Flush, PC_Write}, 4'b0001);
      next();

      // IRQ entry, masking, ERET, re-entry
      do_reset();
      idle(); IRQ = 1'b1; ID_PC_plus4 = 32'h0040_0010;
      mid(); check("irq_run", PC_Sel, 2'd0); next();
      mid(); check("irq_pend", PC_Sel, 2'd0); next();
      mid(); check("irq_take", {PC_Sel, IF_ID_Flush, ID_EX_Flush, PC_Write}, 5'b11111); next();
      mid();
      check("irq_epc", EPC, 32'h0040_000C);
      check("irq_active", Irq_Active, 1'b1);
      for (int i = 0; i < 3; i++) begin
         next(); mid();
         check("irq_masked", PC_Sel, 2'd0);
      end
      next();
      ID_isEret = 1'b1;
      mid(); next();
      ID_isEret = 1'b0; ID_PC_plus4 = 32'h0040_0020;
      mid(); check("eret_clears", Irq_Active, 1'b0); next();
      mid(); check("reirq_pend", PC_Sel, 2'd0); next();
      mid(); check("reirq_take", PC_Sel, 2'd3); next();
      mid(); check("reirq_epc", EPC, 32'h0040_001C);
      next();

      // IRQ held off by a branch in EX for two cycles
      do_reset();
      idle(); IRQ = 1'b1; ID_PC_plus4 = 32'h0040_0100;
      next();
      EX_isBranch = 1'b1;
      mid(); check("irq_br_wait1", PC_Sel, 2'd0); next();
      mid(); check("irq_br_wait2", PC_Sel, 2'd0); next();
      EX_isBranch = 1'b0;
      mid(); check("irq_br_slot", PC_Sel, 2'd0); next();
      mid(); check("irq_br_take", PC_Sel, 2'd3); next();
      mid(); check("irq_br_epc", EPC, 32'h0040_00FC);
      next();

      // Kernel-mode PC blocks IRQ
      do_reset();
      idle(); IRQ = 1'b1; ID_PC_plus4 = 32'h8000_0004;
      for (int i = 0; i < 4; i++) begin
         mid(); check("irq_kernel", PC_Sel, 2'd0); next();
      end
      mid(); check("irq_kernel_inactive", Irq_Active, 1'b0);
      next();

      // IRQ dropping while pending returns to RUN
      do_reset();
      idle(); IRQ = 1'b1;
      next();
      IRQ = 1'b0;
      mid(); next();
      mid(); check("irq_drop", PC_Sel, 2'd0); next();
      mid(); check("irq_drop2", PC_Sel, 2'd0); next();

      // EPC wraps below address zero
      do_reset();
      idle(); IRQ = 1'b1; ID_PC_plus4 = 32'h0;
      next(); next();
      mid(); check("wrap_take", PC_Sel, 2'd3); next();
      IRQ = 1'b0;
      mid(); check("wrap_epc", EPC, 32'hFFFF_FFFC);
      next();

      // Reset pulsed during IRQ_TAKE: no EPC write
      do_reset();
      idle(); IRQ = 1'b1; ID_PC_plus4 = 32'h0040_0010;
      next(); next();
      mid(); check("rst_take_seen", PC_Sel, 2'd3);
      #1;
      reset = 1'b0; IRQ = 1'b0;
      next();
      check("rst_take_epc", EPC, 32'h0);
      check("rst_take_active", Irq_Active, 1'b0);
      reset = 1'b1;
      mid(); check("rst_take_run", {PC_Sel, PC_Write}, 3'b001); next();
      mid(); check("rst_take_run2", PC_Sel, 2'd0); next();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
